// File: rtl/segment_descriptor_loader.sv
// Segment descriptor loader: fetches an 8-byte GDT/LDT descriptor, checks the limit and attributes,
// and fills a segment-register shadow cache that has a combinational read port.
module segment_descriptor_loader #(
  parameter int BUS_WIDTH = 32,
  parameter int SEG_COUNT = 6,
  parameter int SEG_IDX_W = $clog2(SEG_COUNT)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [SEG_IDX_W-1:0] load_segment,
  input  logic [15:0]          load_selector,
  input  logic [31:0]          gdt_base,
  input  logic [31:0]          ldt_base,
  input  logic [15:0]          gdt_limit,
  input  logic [15:0]          ldt_limit,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  input  logic                 mem_ack,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  output logic                 done_valid,
  output logic                 done_fault,
  output logic [7:0]           done_vector,
  output logic [15:0]          done_error_code,
  input  logic                 invalidate_all,
  input  logic [SEG_IDX_W-1:0] read_segment,
  output logic                 read_valid,
  output logic [31:0]          read_base,
  output logic [31:0]          read_limit,
  output logic [11:0]          read_attr
);

  localparam int          BEATS     = 64 / BUS_WIDTH;
  localparam logic [31:0] BYTE_STEP = 32'(BUS_WIDTH / 8);
  localparam logic [7:0]  VEC_GP    = 8'd13;
  localparam logic [7:0]  VEC_NP    = 8'd11;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_DECODE, S_DONE} state_t;

  state_t               r_state;
  logic                 r_load_ready;
  logic                 r_mem_req;
  logic [31:0]          r_mem_addr;
  logic                 r_done_valid;
  logic                 r_done_fault;
  logic [7:0]           r_done_vector;
  logic [15:0]          r_done_error_code;
  logic [15:0]          r_sel;
  logic [SEG_IDX_W-1:0] r_seg;
  logic [31:0]          r_tbase;
  logic [15:0]          r_tlimit;
  logic [1:0]           r_beat;
  logic [63:0]          r_desc;

  logic                 r_valid [SEG_COUNT];
  logic [31:0]          r_base  [SEG_COUNT];
  logic [31:0]          r_limit [SEG_COUNT];
  logic [11:0]          r_attr  [SEG_COUNT];

  function automatic logic [31:0] f_expand_limit(input logic [19:0] lim, input logic g);
    return g ? {lim, 12'hFFF} : {12'h000, lim};
  endfunction

  logic [12:0] w_index;
  logic        w_null;
  logic        w_over;
  logic        w_last;
  logic [15:0] w_err_code;
  logic [31:0] w_base;
  logic [31:0] w_limit;
  logic [11:0] w_attr;
  logic        w_unused;

  assign w_index    = r_sel[15:3];
  assign w_null     = (r_sel[15:2] == 14'd0);
  assign w_over     = ({1'b0, w_index, 3'b111} > {1'b0, r_tlimit});
  assign w_last     = (r_beat == 2'(BEATS - 1));
  assign w_err_code = {r_sel[15:2], 2'b00};
  assign w_base     = {r_desc[63:56], r_desc[39:32], r_desc[31:16]};
  assign w_limit    = f_expand_limit({r_desc[51:48], r_desc[15:0]}, r_desc[55]);
  assign w_attr     = {r_desc[55], r_desc[54], 1'b0, r_desc[52], r_desc[47],
                       r_desc[46:45], r_desc[44], r_desc[43:40]};
  assign w_unused   = ^{r_desc[53], r_sel[1:0]};

  assign load_ready      = r_load_ready;
  assign mem_req         = r_mem_req;
  assign mem_addr        = r_mem_addr;
  assign done_valid      = r_done_valid;
  assign done_fault      = r_done_fault;
  assign done_vector     = r_done_vector;
  assign done_error_code = r_done_error_code;

  always_comb begin
    read_valid = 1'b0;
    read_base  = 32'h0;
    read_limit = 32'h0;
    read_attr  = 12'h0;
    for (int i = 0; i < SEG_COUNT; i++) begin
      if (read_segment == SEG_IDX_W'(i)) begin
        read_valid = r_valid[i];
        read_base  = r_base[i];
        read_limit = r_limit[i];
        read_attr  = r_attr[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_load_ready      <= 1'b1;
      r_mem_req         <= 1'b0;
      r_mem_addr        <= 32'h0;
      r_done_valid      <= 1'b0;
      r_done_fault      <= 1'b0;
      r_done_vector     <= 8'h0;
      r_done_error_code <= 16'h0;
      r_beat            <= 2'd0;
      for (int i = 0; i < SEG_COUNT; i++) begin
        r_valid[i] <= 1'b0;
        r_base[i]  <= 32'h0;
        r_limit[i] <= 32'h0;
        r_attr[i]  <= 12'h0;
      end
    end else begin
      // Clear first so that a same-cycle entry write below takes precedence.
      if (invalidate_all) begin
        for (int i = 0; i < SEG_COUNT; i++) r_valid[i] <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_sel        <= load_selector;
            r_seg        <= load_segment;
            r_tbase      <= load_selector[2] ? ldt_base  : gdt_base;
            r_tlimit     <= load_selector[2] ? ldt_limit : gdt_limit;
            r_load_ready <= 1'b0;
            r_state      <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_null) begin
            for (int i = 0; i < SEG_COUNT; i++) begin
              if (r_seg == SEG_IDX_W'(i)) r_valid[i] <= 1'b0;
            end
            r_done_valid <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_over) begin
            r_done_valid      <= 1'b1;
            r_done_fault      <= 1'b1;
            r_done_vector     <= VEC_GP;
            r_done_error_code <= w_err_code;
            r_state           <= S_DONE;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_tbase + {16'h0, w_index, 3'b000};
            r_beat     <= 2'd0;
            r_state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (mem_ack) begin
            for (int b = 0; b < BEATS; b++) begin
              if (r_beat == 2'(b)) r_desc[b*BUS_WIDTH +: BUS_WIDTH] <= mem_rdata;
            end
            if (w_last) begin
              r_mem_req <= 1'b0;
              r_state   <= S_DECODE;
            end else begin
              r_beat     <= r_beat + 2'd1;
              r_mem_addr <= r_mem_addr + BYTE_STEP;
            end
          end
        end

        S_DECODE: begin
          r_done_valid <= 1'b1;
          r_state      <= S_DONE;
          if (!r_desc[44]) begin
            r_done_fault      <= 1'b1;
            r_done_vector     <= VEC_GP;
            r_done_error_code <= w_err_code;
          end else if (!r_desc[47]) begin
            r_done_fault      <= 1'b1;
            r_done_vector     <= VEC_NP;
            r_done_error_code <= w_err_code;
          end else begin
            for (int i = 0; i < SEG_COUNT; i++) begin
              if (r_seg == SEG_IDX_W'(i)) begin
                r_valid[i] <= 1'b1;
                r_base[i]  <= w_base;
                r_limit[i] <= w_limit;
                r_attr[i]  <= w_attr;
              end
            end
          end
        end

        S_DONE: begin
          r_done_valid      <= 1'b0;
          r_done_fault      <= 1'b0;
          r_done_vector     <= 8'h0;
          r_done_error_code <= 16'h0;
          r_load_ready      <= 1'b1;
          r_state           <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
